// File: rtl/result_wb_arbiter.sv
// Round-robin write-back arbiter: grants one engine per transaction, captures its
// result word and turns it into a registered frame-buffer write with pixel/frame tracking.
module result_wb_arbiter #(
  parameter int unsigned NUM_PROC = 12,
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                clk_iCLK,
  input  logic                reset,
  input  logic                wb_enable,
  input  logic [NUM_PROC-1:0] engine_req,
  output logic [NUM_PROC-1:0] req_ack,
  input  logic [26:0]         eng_word,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [7:0]          wr_data,
  output logic [ADDR_W-1:0]   pix_count,
  output logic                frame_done,
  output logic                err_range
);

  localparam int unsigned IDX_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int unsigned FRAME_PIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIX - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PROC - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] iter;
  } result_t;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [NUM_PROC-1:0] ack_q, ack_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic                wrap_q, wrap_d;
  logic                fd_q, fd_d;
  logic                err_q, err_d;

  logic                found_c;
  logic [IDX_W-1:0]    pick_c;
  logic [IDX_W-1:0]    idx_c;
  result_t             word_c;
  logic                in_range_c;
  logic [ADDR_W-1:0]   addr_c;

  // x + y*H_RES as a sum of shifted copies of y, one per set bit of H_RES
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(x);
    for (int i = 0; i < 32; i++) begin
      if (H_RES[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

  // Rotating search starting one past the last served engine
  always_comb begin
    found_c = 1'b0;
    pick_c  = last_q;
    idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_PROC; k++) begin
      idx_c = IDX_W'((32'(last_q) + k) % NUM_PROC);
      if (!found_c && engine_req[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  always_ff @(posedge clk_iCLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= LAST_IDX;
      win_q   <= '0;
      ack_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pix_q   <= '0;
      wrap_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      ack_q   <= ack_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      wrap_q  <= wrap_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    ack_d      = '0;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    pix_d      = pix_q;
    wrap_d     = 1'b0;
    fd_d       = wrap_q;
    err_d      = err_q;
    word_c     = result_t'(eng_word);
    in_range_c = (32'(word_c.x) < H_RES) && (32'(word_c.y) < V_RES);
    addr_c     = lin_addr(word_c.x, word_c.y);

    unique case (state_q)
      S_IDLE: begin
        if (wb_enable && found_c) begin
          state_d       = S_GRANT;
          win_d         = pick_c;
          ack_d[pick_c] = 1'b1;
        end
      end
      S_GRANT: begin
        // Transaction completes regardless of wb_enable once granted
        state_d = S_RELEASE;
        last_d  = win_q;
        if (in_range_c) begin
          wr_en_d = 1'b1;
          addr_d  = addr_c;
          data_d  = word_c.iter;
          wrap_d  = (pix_q == LAST_PIX);
          pix_d   = (pix_q == LAST_PIX) ? '0 : pix_q + ADDR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign req_ack    = ack_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign pix_count  = pix_q;
  assign frame_done = fd_q;
  assign err_range  = err_q;

endmodule

// File: tb/tb_result_wb_arbiter.sv
// Scoreboard bench for result_wb_arbiter: batches of engine results are predicted by a
// rotation/arithmetic model and checked by an independent monitor on grants and writes.
module tb_result_wb_arbiter;

  localparam int NP    = 12;
  localparam int HR    = 640;
  localparam int VR    = 12;
  localparam int AW    = 19;
  localparam int FRAME = HR * VR;

  logic          clk;
  logic          reset;
  logic          wb_enable;
  logic [NP-1:0] engine_req;
  logic [NP-1:0] req_ack;
  logic [26:0]   eng_word;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] pix_count;
  logic          frame_done;
  logic          err_range;

  result_wb_arbiter #(
    .NUM_PROC(NP),
    .H_RES   (HR),
    .V_RES   (VR),
    .ADDR_W  (AW)
  ) dut (
    .clk_iCLK  (clk),
    .reset     (reset),
    .wb_enable (wb_enable),
    .engine_req(engine_req),
    .req_ack   (req_ack),
    .eng_word  (eng_word),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pix_count (pix_count),
    .frame_done(frame_done),
    .err_range (err_range)
  );

  typedef struct {
    int eng;
    bit wr;
    int addr;
    int data;
    bit err;
    int pix;
    bit fd;
    int gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [26:0] wq[NP][$];
  logic [26:0] bw[NP];

  int n_cmp    = 0;
  int n_bad    = 0;
  int m_last   = NP - 1;
  int m_pix    = 0;
  int m_writes = 0;
  int m_frames = 0;
  bit m_err    = 0;
  int fd_seen  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [26:0] mkword(int x, int y, int it);
    return {10'(x), 9'(y), 8'(it)};
  endfunction

  function automatic logic [26:0] rand_word(bit allow_bad);
    int x, y;
    x = int'($urandom_range(HR - 1, 0));
    y = int'($urandom_range(VR - 1, 0));
    if (allow_bad && $urandom_range(7, 0) == 0) begin
      if ($urandom_range(1, 0) == 1) x = int'($urandom_range(1023, HR));
      else                           y = int'($urandom_range(511, VR));
    end
    return mkword(x, y, int'($urandom_range(255, 0)));
  endfunction

  function automatic int pending();
    int s;
    s = exp_q.size();
    for (int i = 0; i < NP; i++) s += wq[i].size();
    return s;
  endfunction

  // Reference: all masked engines request together, so service order is the
  // rotation starting after the last served engine; each result is one expected transaction.
  task automatic launch(input logic [NP-1:0] mask, input bit gapchk);
    int base;
    bit first;
    base  = m_last;
    first = 1'b1;
    for (int k = 1; k <= NP; k++) begin
      int   i;
      int   x, y;
      exp_t e;
      i = (base + k) % NP;
      if (mask[i]) begin
        x      = int'(bw[i][26:17]);
        y      = int'(bw[i][16:8]);
        e.eng  = i;
        e.wr   = (x < HR) && (y < VR);
        e.addr = x + y * HR;
        e.data = int'(bw[i][7:0]);
        e.fd   = 1'b0;
        if (e.wr) begin
          m_pix = (m_pix + 1) % FRAME;
          m_writes++;
          e.fd = (m_pix == 0);
          if (e.fd) m_frames++;
        end else begin
          m_err = 1'b1;
        end
        e.err  = m_err;
        e.pix  = m_pix;
        e.gap  = (first || !gapchk) ? 0 : 3;
        first  = 1'b0;
        m_last = i;
        exp_q.push_back(e);
        wq[i].push_back(bw[i]);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (pending() != 0) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        chk("drain_timeout", 64'(pending()), 64'd0);
        return;
      end
    end
    #1;
  endtask

  // Engines: hold request while holding a result, drive the bus while acked, drop after ack
  initial begin
    logic [NP-1:0] acked;
    engine_req = '0;
    eng_word   = '0;
    forever begin
      @(negedge clk);
      acked    = req_ack;
      eng_word = 27'($urandom);
      for (int i = 0; i < NP; i++)
        if (acked[i] && wq[i].size() > 0) eng_word = wq[i][0];
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (acked[i]) begin
          if (wq[i].size() > 0) wq[i].delete(0);
          engine_req[i] = 1'b0;
        end else begin
          engine_req[i] = (wq[i].size() > 0);
        end
      end
    end
  end

  // Monitor: grant slot, then write slot one cycle later, then frame_done slot
  initial begin
    exp_t wp;
    bit   wp_v;
    bit   fd_v;
    bit   fd_e;
    int   cyc;
    int   last_ack_cyc;
    wp_v = 1'b0;
    fd_v = 1'b0;
    fd_e = 1'b0;
    cyc  = 0;
    last_ack_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        wp_v = 1'b0;
        fd_v = 1'b0;
      end else begin
        if (fd_v) begin
          chk("frame_done", 64'(frame_done), 64'(fd_e));
          if (frame_done) fd_seen++;
          fd_v = 1'b0;
        end else if (frame_done) begin
          chk("frame_done_spurious", 64'(frame_done), 64'd0);
        end
        if (wp_v) begin
          chk("wr_en", 64'(wr_en), 64'(wp.wr));
          if (wp.wr) begin
            chk("wr_addr", 64'(wr_addr), 64'(wp.addr));
            chk("wr_data", 64'(wr_data), 64'(wp.data));
            fd_v = 1'b1;
            fd_e = wp.fd;
          end
          chk("err_range", 64'(err_range), 64'(wp.err));
          chk("pix_count", 64'(pix_count), 64'(wp.pix));
          wp_v = 1'b0;
        end else if (wr_en) begin
          chk("wr_en_spurious", 64'(wr_en), 64'd0);
        end
        if (req_ack != '0) begin
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", 64'(req_ack), 64'd0);
          end else begin
            wp = exp_q.pop_front();
            chk("req_ack", 64'(req_ack), 64'(1) << wp.eng);
            if (wp.gap != 0) chk("grant_gap", 64'(cyc - last_ack_cyc), 64'(wp.gap));
            last_ack_cyc = cyc;
            wp_v = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_req_ack"},    64'(req_ack),    64'd0);
    chk({tag, "_wr_en"},      64'(wr_en),      64'd0);
    chk({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
    chk({tag, "_wr_data"},    64'(wr_data),    64'd0);
    chk({tag, "_pix_count"},  64'(pix_count),  64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_err_range"},  64'(err_range),  64'd0);
  endtask

  initial begin
    int            t;
    logic [NP-1:0] mask;
    reset     = 1'b1;
    wb_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #1 reset = 1'b0;

    // Every engine at once: order 0..11, three cycles apart
    for (int i = 0; i < NP; i++) bw[i] = rand_word(1'b0);
    launch('1, 1'b1);
    wait_drain();

    bw[2] = mkword(5, 2, 'h3C);
    launch(NP'(12'h004), 1'b0);
    wait_drain();

    // Grants blocked while disabled; dropping enable mid-transaction still writes
    wb_enable = 1'b0;
    bw[0] = rand_word(1'b0);
    launch(NP'(12'h001), 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("ack_while_disabled", 64'(req_ack), 64'd0);
    end
    #1 wb_enable = 1'b1;
    @(negedge clk);
    chk("ack_after_enable", 64'(req_ack), 64'd1);
    #1 wb_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1 wb_enable = 1'b1;
    wait_drain();

    // Random batches long enough to wrap the frame
    while (m_writes < FRAME + 40) begin
      mask = NP'($urandom | $urandom);
      if (mask == '0) mask = NP'(1) << $urandom_range(NP - 1, 0);
      for (int i = 0; i < NP; i++) bw[i] = rand_word(1'b0);
      launch(mask, 1'b1);
      wait_drain();
    end

    bw[4] = mkword(640, 0, 'h11);
    launch(NP'(12'h010), 1'b0);
    wait_drain();
    bw[9] = mkword(HR - 1, VR - 1, 'hA5);
    launch(NP'(12'h200), 1'b0);
    wait_drain();
    bw[6] = mkword(3, VR, 'h22);
    launch(NP'(12'h040), 1'b0);
    wait_drain();

    repeat (40) begin
      mask = NP'($urandom | $urandom);
      if (mask == '0) mask = NP'(1);
      for (int i = 0; i < NP; i++) bw[i] = rand_word(1'b1);
      launch(mask, 1'b1);
      wait_drain();
    end

    // Reset during GRANT discards the captured word and restarts rotation at engine 0
    bw[7] = mkword(1000, 1, 'h77);
    launch(NP'(12'h080), 1'b0);
    t = 0;
    @(negedge clk);
    while (req_ack == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midgrant_ack", 64'(req_ack), 64'h080);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_zero("midgrant_reset");
    exp_q.delete();
    for (int i = 0; i < NP; i++) wq[i].delete();
    m_last = NP - 1;
    m_pix  = 0;
    m_err  = 1'b0;
    #1 reset = 1'b0;
    bw[0] = rand_word(1'b0);
    bw[3] = rand_word(1'b0);
    bw[9] = rand_word(1'b0);
    launch(NP'(12'h209), 1'b1);
    wait_drain();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_pulses", 64'(fd_seen), 64'(m_frames));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
